// File: rtl/axis_dm_pkg.sv
// Shared definitions for the DataMover command arbiter.
// Holds register offsets, command field positions, the readback signature
// and the arbiter state encoding.
package axis_dm_pkg;

  // Write offsets within a stream's 8-word register page
  localparam logic [2:0] OFF_CLEAR   = 3'd0;
  localparam logic [2:0] OFF_ADDR    = 3'd1;
  localparam logic [2:0] OFF_SIZE    = 3'd2;
  localparam logic [2:0] OFF_POP     = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;

  // Read offsets
  localparam logic [2:0] OFF_STS     = 3'd4;
  localparam logic [2:0] OFF_STS_CNT = 3'd5;
  localparam logic [2:0] OFF_CMD_CNT = 3'd6;
  localparam logic [2:0] OFF_OUT_CNT = 3'd7;

  localparam logic [15:0] SIGNATURE    = 16'hace0;
  localparam logic [31:0] READ_DEFAULT = 32'h12345678;

  // Command layout: [71:68]=0, [67:64]=tag, [63:32]=addr, [31]=DRR,
  // [30]=EOF, [29:24]=0, [23]=INCR, [22:0]=BTT
  localparam int BTT_W        = 23;
  localparam int CMD_DRR_BIT  = 31;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_INCR_BIT = 23;

  // Arbiter states
  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  // Control bits [31:23] of a command word; INCR is always set
  function automatic logic [8:0] cmd_ctl(input logic drr, input logic eof);
    return {drr, eof, 6'b0, 1'b1};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Ports: clk/rst (sync, active-high), clr (synchronous flush), push/din,
// pop/dout, full, empty, count (0..DEPTH). Push while full is ignored unless
// a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/axis_dm_cmd_arbiter.sv
// Multi-stream command front-end for the AXI DataMover.
// Ports: clk/rst (sync, active-high); M_AXIS_CMD_* command master;
// S_AXIS_STS_* status slave (tag in TDATA[3:0]); set_* settings-bus writes;
// get_addr/get_data combinational readback; stream_ready per-stream issue
// gate; sts_pending per-stream status-available flags; debug snapshot
// {state, rr_ptr, total outstanding, grant, 32'b0} as bytes.
module axis_dm_cmd_arbiter
  import axis_dm_pkg::*;
#(
  parameter int NUM_STREAMS     = 4,
  parameter int STREAM_W        = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int CMD_W           = 72,
  parameter int STS_W           = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PAGEWIDTH       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   M_AXIS_CMD_TVALID,
  input  logic                   M_AXIS_CMD_TREADY,
  output logic [CMD_W-1:0]       M_AXIS_CMD_TDATA,
  input  logic                   S_AXIS_STS_TVALID,
  output logic                   S_AXIS_STS_TREADY,
  input  logic [STS_W-1:0]       S_AXIS_STS_TDATA,
  input  logic [DATA_W-1:0]      set_data,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   set_stb,
  input  logic [ADDR_W-1:0]      get_addr,
  output logic [DATA_W-1:0]      get_data,
  input  logic [NUM_STREAMS-1:0] stream_ready,
  output logic [NUM_STREAMS-1:0] sts_pending,
  output logic [63:0]            debug
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int ENT_W = ADDR_W + BTT_W;

  // Register decode
  logic [PAGEWIDTH-3:0] set_w, get_w;
  logic [STREAM_W-1:0]  set_m, get_m;
  logic [2:0]           set_off, get_off;
  logic                 set_ok, get_ok;

  assign set_w   = set_addr[PAGEWIDTH-1:2];
  assign get_w   = get_addr[PAGEWIDTH-1:2];
  assign set_m   = set_w[STREAM_W+2:3];
  assign get_m   = get_w[STREAM_W+2:3];
  assign set_off = set_w[2:0];
  assign get_off = get_w[2:0];
  assign set_ok  = set_stb && (int'(set_m) < NUM_STREAMS);
  assign get_ok  = int'(get_m) < NUM_STREAMS;

  // Per-stream state
  logic [ADDR_W-1:0]      stage_addr [NUM_STREAMS];
  logic [2:0]             ctrl       [NUM_STREAMS];
  logic [ENT_W-1:0]       cmd_head   [NUM_STREAMS];
  logic [STS_W-1:0]       sts_head   [NUM_STREAMS];
  logic [CNT_W-1:0]       cmd_cnt    [NUM_STREAMS];
  logic [CNT_W-1:0]       sts_cnt    [NUM_STREAMS];
  logic [OUT_W-1:0]       out_cnt    [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] ovf, zero_err, clr, elig;
  logic [NUM_STREAMS-1:0] cmd_push, cmd_pop, cmd_full, cmd_empty;
  logic [NUM_STREAMS-1:0] sts_hit, sts_pop, sts_full, sts_empty;

  // Arbiter / issue state
  logic [0:0]          state;
  logic [STREAM_W-1:0] rr_ptr, grant, grant_next;
  logic                grant_found, issue_done, issue_flushed;
  logic [CMD_W-1:0]    cmd_reg;
  logic [OUT_W-1:0]    total;

  // Status path
  logic       sts_en, sts_hs, tag_ok, tag_full;
  logic [3:0] sts_tag;

  for (genvar i = 0; i < NUM_STREAMS; i++) begin : g_stream
    sync_fifo #(.WIDTH(ENT_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
      .clk(clk), .rst(rst), .clr(clr[i]), .push(cmd_push[i]), .pop(cmd_pop[i]),
      .din({stage_addr[i], set_data[BTT_W-1:0]}), .dout(cmd_head[i]),
      .full(cmd_full[i]), .empty(cmd_empty[i]), .count(cmd_cnt[i])
    );
    sync_fifo #(.WIDTH(STS_W), .DEPTH(FIFO_DEPTH)) u_sts_fifo (
      .clk(clk), .rst(rst), .clr(clr[i]), .push(sts_hit[i]), .pop(sts_pop[i]),
      .din(S_AXIS_STS_TDATA), .dout(sts_head[i]),
      .full(sts_full[i]), .empty(sts_empty[i]), .count(sts_cnt[i])
    );
    // A clear of the granted stream during ISSUE already emptied its FIFO;
    // popping at handshake would discard a command pushed after the clear.
    assign cmd_pop[i] = issue_done && !issue_flushed && (grant == STREAM_W'(i));
    assign sts_hit[i] = sts_hs && (sts_tag == 4'(i));
    assign elig[i]    = !cmd_empty[i] && ctrl[i][0] && stream_ready[i];
  end

  // Settings-bus write strobes
  always_comb begin
    clr      = '0;
    cmd_push = '0;
    sts_pop  = '0;
    if (set_ok) begin
      case (set_off)
        OFF_CLEAR: clr[set_m]      = 1'b1;
        OFF_SIZE:  cmd_push[set_m] = (set_data[BTT_W-1:0] != '0) && !cmd_full[set_m];
        OFF_POP:   sts_pop[set_m]  = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        stage_addr[i] <= '0;
        ctrl[i]       <= '0;
      end
      ovf      <= '0;
      zero_err <= '0;
    end else if (set_ok) begin
      case (set_off)
        OFF_CLEAR: begin
          ovf[set_m]      <= 1'b0;
          zero_err[set_m] <= 1'b0;
        end
        OFF_ADDR: stage_addr[set_m] <= ADDR_W'(set_data);
        OFF_SIZE: begin
          if (set_data[BTT_W-1:0] == '0) zero_err[set_m] <= 1'b1;
          else if (cmd_full[set_m])      ovf[set_m]      <= 1'b1;
        end
        OFF_CTRL: ctrl[set_m] <= set_data[2:0];
        default: ;
      endcase
    end
  end

  // Round-robin search: first eligible stream at or after rr_ptr
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_next  = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_STREAMS;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        grant_next  = STREAM_W'(idx);
      end
    end
  end

  assign issue_done = (state == ST_ISSUE) && M_AXIS_CMD_TREADY;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_ARB;
      rr_ptr        <= '0;
      grant         <= '0;
      cmd_reg       <= '0;
      issue_flushed <= 1'b0;
    end else begin
      case (state)
        ST_ARB: begin
          if (grant_found && (int'(total) < MAX_OUTSTANDING)) begin
            grant         <= grant_next;
            cmd_reg       <= {4'b0, 4'(grant_next),
                              cmd_head[grant_next][ENT_W-1:BTT_W],
                              cmd_ctl(ctrl[grant_next][2], ctrl[grant_next][1]),
                              cmd_head[grant_next][BTT_W-1:0]};
            issue_flushed <= 1'b0;
            state         <= ST_ISSUE;
          end
        end
        default: begin
          if (clr[grant]) issue_flushed <= 1'b1;
          if (M_AXIS_CMD_TREADY) begin
            rr_ptr <= (grant == STREAM_W'(NUM_STREAMS - 1)) ? '0 : grant + 1'b1;
            state  <= ST_ARB;
          end
        end
      endcase
    end
  end

  assign M_AXIS_CMD_TVALID = (state == ST_ISSUE);
  assign M_AXIS_CMD_TDATA  = cmd_reg;

  // Status routing; out-of-range tags are accepted and dropped
  assign sts_tag = S_AXIS_STS_TDATA[3:0];

  always_comb begin
    tag_ok   = 1'b0;
    tag_full = 1'b0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      if (sts_tag == 4'(i)) begin
        tag_ok   = 1'b1;
        tag_full = sts_full[i];
      end
    end
  end

  assign S_AXIS_STS_TREADY = sts_en && !(tag_ok && tag_full);
  assign sts_hs            = S_AXIS_STS_TVALID && S_AXIS_STS_TREADY;

  always_ff @(posedge clk) begin
    if (rst) sts_en <= 1'b0;
    else     sts_en <= 1'b1;
  end

  // Increment first, then saturating decrement, so issue+status nets to zero
  function automatic logic [OUT_W-1:0] sat_step(input logic [OUT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [OUT_W-1:0] n;
    n = c + OUT_W'(inc);
    if (dec && (n != '0)) n = n - 1'b1;
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      total <= '0;
      for (int unsigned i = 0; i < NUM_STREAMS; i++) out_cnt[i] <= '0;
    end else begin
      total <= sat_step(total, issue_done, sts_hs && tag_ok);
      for (int unsigned i = 0; i < NUM_STREAMS; i++)
        out_cnt[i] <= sat_step(out_cnt[i], issue_done && (grant == STREAM_W'(i)), sts_hit[i]);
    end
  end

  // Readback
  always_comb begin
    get_data = DATA_W'(READ_DEFAULT);
    if (get_off == OFF_CLEAR) begin
      get_data = DATA_W'({SIGNATURE, 16'(get_m)});
    end else if (get_ok) begin
      case (get_off)
        OFF_STS:     get_data = DATA_W'({sts_empty[get_m], ovf[get_m], zero_err[get_m],
                                         21'b0, 8'(sts_head[get_m])});
        OFF_STS_CNT: get_data = DATA_W'(sts_cnt[get_m]);
        OFF_CMD_CNT: get_data = DATA_W'(cmd_cnt[get_m]);
        OFF_OUT_CNT: get_data = DATA_W'(out_cnt[get_m]);
        default: ;
      endcase
    end
  end

  assign sts_pending = ~sts_empty;
  assign debug       = {8'(state), 8'(rr_ptr), 8'(total), 8'(grant), 32'b0};

  logic unused_bits;
  assign unused_bits = ^{set_addr, get_addr, set_data, S_AXIS_STS_TDATA};

endmodule

// File: tb/tb_axis_dm_cmd_arbiter.sv
module tb_axis_dm_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_AXIS_CMD_TVALID;
  logic        M_AXIS_CMD_TREADY = 1'b0;
  logic [71:0] M_AXIS_CMD_TDATA;
  logic        S_AXIS_STS_TVALID = 1'b0;
  logic        S_AXIS_STS_TREADY;
  logic [7:0]  S_AXIS_STS_TDATA = '0;
  logic [31:0] set_data = '0;
  logic [31:0] set_addr = '0;
  logic        set_stb = 1'b0;
  logic [31:0] get_addr = '0;
  logic [31:0] get_data;
  logic [3:0]  stream_ready = '1;
  logic [3:0]  sts_pending;
  logic [63:0] debug;

  axis_dm_cmd_arbiter #(
    .NUM_STREAMS(4), .STREAM_W(2), .ADDR_W(32), .DATA_W(32), .CMD_W(72),
    .STS_W(8), .FIFO_DEPTH(16), .MAX_OUTSTANDING(4), .PAGEWIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .M_AXIS_CMD_TVALID(M_AXIS_CMD_TVALID), .M_AXIS_CMD_TREADY(M_AXIS_CMD_TREADY),
    .M_AXIS_CMD_TDATA(M_AXIS_CMD_TDATA),
    .S_AXIS_STS_TVALID(S_AXIS_STS_TVALID), .S_AXIS_STS_TREADY(S_AXIS_STS_TREADY),
    .S_AXIS_STS_TDATA(S_AXIS_STS_TDATA),
    .set_data(set_data), .set_addr(set_addr), .set_stb(set_stb),
    .get_addr(get_addr), .get_data(get_data),
    .stream_ready(stream_ready), .sts_pending(sts_pending), .debug(debug)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [71:0] exp_q [$];
  logic [7:0]  sts_q [$];
  bit          auto_sts = 1'b0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] mk_cmd(input int m, input logic [31:0] a,
                                         input logic drr, input logic eof,
                                         input logic [22:0] btt);
    return {4'h0, 4'(m), a, drr, eof, 6'b0, 1'b1, btt};
  endfunction

  function automatic logic [31:0] ra(input int m, input int off);
    return 32'(m * 32 + off * 4);
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    set_addr = a; set_data = d; set_stb = 1'b1;
    @(negedge clk);
    set_stb = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    get_addr = a;
    #1;
    d = get_data;
    @(negedge clk);
  endtask

  task automatic push_cmd(input int m, input logic [31:0] a, input logic [22:0] btt,
                          input logic drr, input logic eof, input bit expect_it);
    wr(ra(m, 1), a);
    if (expect_it) exp_q.push_back(mk_cmd(m, a, drr, eof, btt));
    wr(ra(m, 2), 32'(btt));
  endtask

  task automatic wait_exp_empty(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check_eq(tag, 72'(exp_q.size()), 72'(0));
  endtask

  task automatic wait_sts_drained();
    int unsigned n;
    n = 0;
    while ((sts_q.size() != 0 || S_AXIS_STS_TVALID) && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tvalid(input string tag);
    int unsigned n;
    n = 0;
    while (!M_AXIS_CMD_TVALID && n < 50) begin @(negedge clk); n++; end
    check_eq(tag, 72'(M_AXIS_CMD_TVALID), 72'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    sts_q.delete();
  endtask

  // Command monitor: handshake decided at the coming posedge
  always @(negedge clk) begin
    #2;
    if (!rst && M_AXIS_CMD_TVALID && M_AXIS_CMD_TREADY) begin
      if (exp_q.size() == 0) check_eq("cmd_extra", M_AXIS_CMD_TDATA, '0);
      else                   check_eq("cmd", M_AXIS_CMD_TDATA, exp_q.pop_front());
      if (auto_sts) sts_q.push_back({4'h8, M_AXIS_CMD_TDATA[67:64]});
    end
  end

  // Status responder: owns the S_AXIS_STS signals
  initial begin
    forever begin
      @(negedge clk);
      if (sts_q.size() != 0 && !rst) begin
        int unsigned w;
        w = 0;
        S_AXIS_STS_TDATA  = sts_q[0];
        S_AXIS_STS_TVALID = 1'b1;
        #2;
        while (!S_AXIS_STS_TREADY && w < 200) begin @(negedge clk); #2; w++; end
        if (w >= 200) check_eq("sts_ready_timeout", 72'(w), 72'(0));
        @(posedge clk);
        #1;
        void'(sts_q.pop_front());
        S_AXIS_STS_TVALID = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;

    // Reset state
    do_reset();
    check_eq("sts_tready_after_rst", 72'(S_AXIS_STS_TREADY), 72'(0));
    @(negedge clk);
    check_eq("sts_tready_routed", 72'(S_AXIS_STS_TREADY), 72'(1));
    check_eq("rst_tvalid", 72'(M_AXIS_CMD_TVALID), 72'(0));
    check_eq("rst_sts_pending", 72'(sts_pending), 72'(0));
    rd(ra(2, 0), d); check_eq("sig_s2", 72'(d), 72'(32'hace00002));
    rd(ra(1, 3), d); check_eq("rd_default", 72'(d), 72'(32'h12345678));
    rd(ra(0, 6), d); check_eq("rst_cmd_cnt", 72'(d), 72'(0));

    // Single command on stream 1, status round trip
    M_AXIS_CMD_TREADY = 1'b1;
    wr(ra(1, 4), 32'h3);
    push_cmd(1, 32'h1000_0000, 23'h400, 1'b0, 1'b1, 1'b1);
    wait_exp_empty("t1_issue", 50);
    rd(ra(1, 7), d); check_eq("t1_outstanding", 72'(d), 72'(1));
    sts_q.push_back(8'h81);
    wait_sts_drained();
    check_eq("t1_sts_pending", 72'(sts_pending), 72'(4'b0010));
    rd(ra(1, 4), d); check_eq("t1_sts_word", 72'(d), 72'(32'h0000_0081));
    rd(ra(1, 7), d); check_eq("t1_outstanding_ret", 72'(d), 72'(0));
    wr(ra(1, 3), 32'h0);
    rd(ra(1, 4), d); check_eq("t1_empty_bit", 72'(d[31]), 72'(1));
    rd(ra(1, 5), d); check_eq("t1_sts_cnt", 72'(d), 72'(0));

    // Round robin across 4 streams, 2 commands each
    do_reset();
    auto_sts = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int m = 0; m < 4; m++)
        push_cmd(m, 32'h2000_0000 + 32'(m << 16) + 32'(k << 8),
                 23'(32'h100 * (m + 1) + k), 1'b0, 1'b0, 1'b1);
    stream_ready = '0;
    for (int m = 0; m < 4; m++) wr(ra(m, 4), 32'h1);
    stream_ready = '1;
    wait_exp_empty("t2_issue", 300);
    wait_sts_drained();
    check_eq("t2_sts_pending", 72'(sts_pending), 72'(4'hF));
    rd(ra(3, 5), d); check_eq("t2_sts_cnt3", 72'(d), 72'(2));
    rd(ra(2, 7), d); check_eq("t2_outstanding2", 72'(d), 72'(0));
    auto_sts = 1'b0;

    // Outstanding limit
    do_reset();
    for (int k = 0; k < 6; k++)
      push_cmd(0, 32'h3000_0000 + 32'(k << 12), 23'(16 + k), 1'b1, 1'b0, 1'b1);
    wr(ra(0, 4), 32'h5);
    repeat (30) @(negedge clk);
    check_eq("t3_left_after_4", 72'(exp_q.size()), 72'(2));
    check_eq("t3_tvalid_blocked", 72'(M_AXIS_CMD_TVALID), 72'(0));
    check_eq("t3_total_dbg", 72'(debug[47:40]), 72'(4));
    sts_q.push_back(8'h00);
    repeat (20) @(negedge clk);
    check_eq("t3_fifth_issued", 72'(exp_q.size()), 72'(1));
    sts_q.push_back(8'h00);
    wait_exp_empty("t3_drain", 60);
    wait_sts_drained();

    // FIFO overflow and zero-size errors
    do_reset();
    wr(ra(2, 1), 32'h4000_0000);
    for (int k = 0; k < 17; k++) wr(ra(2, 2), 32'(k + 1));
    rd(ra(2, 6), d); check_eq("t4_cmd_cnt_full", 72'(d), 72'(16));
    rd(ra(2, 4), d); check_eq("t4_ovf", 72'(d[31:29]), 72'(3'b110));
    wr(ra(2, 2), 32'h0);
    rd(ra(2, 4), d); check_eq("t4_zero_err", 72'(d[29]), 72'(1));
    rd(ra(2, 6), d); check_eq("t4_cnt_unchanged", 72'(d), 72'(16));
    wr(ra(2, 0), 32'h0);
    rd(ra(2, 6), d); check_eq("t4_clear_cnt", 72'(d), 72'(0));
    rd(ra(2, 4), d); check_eq("t4_clear_flags", 72'(d[31:29]), 72'(3'b100));

    // TDATA held under backpressure; stream_ready gating
    do_reset();
    M_AXIS_CMD_TREADY = 1'b0;
    wr(ra(1, 4), 32'h1);
    push_cmd(1, 32'h5000_0000, 23'h7FFFFF, 1'b0, 1'b0, 1'b1);
    wait_tvalid("t5_tvalid");
    for (int c = 0; c < 10; c++) begin
      check_eq("t5_hold_data", M_AXIS_CMD_TDATA, exp_q[0]);
      @(negedge clk);
    end
    M_AXIS_CMD_TREADY = 1'b1;
    wait_exp_empty("t5_release", 20);
    stream_ready = 4'b1110;
    wr(ra(0, 4), 32'h1);
    wr(ra(3, 4), 32'h1);
    push_cmd(0, 32'h6000_0000, 23'h10, 1'b0, 1'b0, 1'b0);
    push_cmd(3, 32'h6300_0000, 23'h30, 1'b0, 1'b0, 1'b1);
    wait_exp_empty("t5_skip_s0", 40);
    check_eq("t5_s0_held", 72'(M_AXIS_CMD_TVALID), 72'(0));
    rd(ra(0, 6), d); check_eq("t5_s0_cnt", 72'(d), 72'(1));
    exp_q.push_back(mk_cmd(0, 32'h6000_0000, 1'b0, 1'b0, 23'h10));
    stream_ready = '1;
    wait_exp_empty("t5_s0_go", 40);

    // Reset while a command is waiting in ISSUE
    M_AXIS_CMD_TREADY = 1'b0;
    wr(ra(2, 4), 32'h1);
    push_cmd(2, 32'h7000_0000, 23'h55, 1'b0, 1'b0, 1'b0);
    wait_tvalid("t6_tvalid");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t6_tvalid_dropped", 72'(M_AXIS_CMD_TVALID), 72'(0));
    check_eq("t6_total_dbg", 72'(debug[47:40]), 72'(0));
    check_eq("t6_sts_pending", 72'(sts_pending), 72'(0));
    rd(ra(2, 6), d); check_eq("t6_cmd_cnt", 72'(d), 72'(0));
    rd(ra(0, 7), d); check_eq("t6_out_s0", 72'(d), 72'(0));
    rd(ra(1, 7), d); check_eq("t6_out_s1", 72'(d), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_dm_cmd_arbiter.md
Name: axis_dm_cmd_arbiter

Overview:
Multi-stream command front-end for the AXI DataMover. Software pushes per-stream (address, size) commands through the settings bus. A round-robin arbiter issues them on M_AXIS_CMD with up to MAX_OUTSTANDING transfers in flight. Returned status is routed by tag back to per-stream status FIFOs.

Parameters:
NUM_STREAMS, 4, number of independent command streams (1..16; tag field is 4 bits)
STREAM_W, 2, clog2(NUM_STREAMS), minimum 1
ADDR_W, 32, DataMover address width
DATA_W, 32, settings bus data width
CMD_W, 72, command width (ADDR_W+40)
STS_W, 8, status width
FIFO_DEPTH, 16, per-stream cmd and sts FIFO depth (power of 2)
MAX_OUTSTANDING, 4, commands issued but without returned status (global)
PAGEWIDTH, 16, settings/readback page address bits

Ports:
clk  in  1  clock
rst  in  1  reset
M_AXIS_CMD_TVALID  out  1  command valid
M_AXIS_CMD_TREADY  in  1  command ready
M_AXIS_CMD_TDATA  out  CMD_W  DataMover command
S_AXIS_STS_TVALID  in  1  status valid
S_AXIS_STS_TREADY  out  1  status ready
S_AXIS_STS_TDATA  in  STS_W  status; [3:0]=tag
set_data  in  DATA_W  write data
set_addr  in  ADDR_W  write byte address
set_stb  in  1  write strobe
get_addr  in  ADDR_W  read byte address
get_data  out  DATA_W  read data, combinational
stream_ready  in  NUM_STREAMS  per-stream downstream ready gate
sts_pending  out  NUM_STREAMS  per-stream status FIFO non-empty
debug  out  64  {state, rr_ptr, outstanding, grant stream, zero pad}

Behaviour:
- rst is synchronous, active-high; clock clk. Reset clears all FIFOs, counters, staging registers and ctrl registers. Outputs after reset: TVALID=0, STS_TREADY=0 for one cycle, then per routing; sts_pending=0; ctrl enable=0.
- Register map: word index w = addr[PAGEWIDTH-1:2]; stream m = w[STREAM_W+2:3]; offset = w[2:0].
- Writes:
  - off0 clear: flush cmd and sts FIFOs of stream m, clear its error bits.
  - off1: load addr staging register.
  - off2 size: push {staging addr, set_data[22:0]} into the cmd FIFO.
  - off3: pop the sts FIFO.
  - off4 ctrl: bit0 enable, bit1 EOF, bit2 DRR.
- Reads:
  - off0 {16'hace0, 16'(m)}
  - off4 {empty, ovf, zero_err, 21'b0, sts head}
  - off5 sts count
  - off6 cmd count
  - off7 outstanding for m
  - other offsets 32'h12345678
- Command format:
  - [71:68]=0; [67:64]=m; [63:32]=addr.
  - [31]=DRR; [30]=EOF; [29:24]=0; [23]=1 (INCR); [22:0]=BTT.
- Size write with BTT=0: not pushed; sets zero_err.
- Size write with cmd FIFO full: dropped; sets ovf (sticky until clear).
- Pop on empty FIFO: ignored.
- FSM:
  - ARB: eligible(m) = cmd FIFO non-empty & enable & stream_ready[m]. Grant the first eligible at or after rr_ptr (wrapping) only if total outstanding < MAX_OUTSTANDING. On grant: latch stream and FIFO head into the output register, go ISSUE.
  - ISSUE: TVALID=1 and TDATA held stable. On TREADY: pop the FIFO, increment outstanding[m] and total, rr_ptr = grant+1 mod NUM_STREAMS, return to ARB.
  - Minimum 2 cycles per command; no combinational TREADY→TVALID path.
- Status:
  - STS_TREADY = sts FIFO of tag not full. Tag ≥ NUM_STREAMS: accept and discard.
  - On handshake: push to sts FIFO of tag, decrement outstanding[tag] and total (saturate at 0).
  - Status and issue on the same cycle: total unchanged.
  - Status and software pop on the same cycle on one FIFO: both occur.
- Clear mid-flight: outstanding counters are kept so later status still decrements; the granted command in ISSUE completes. Reset mid-ISSUE drops it.

Decomposition:
- Package axis_dm_pkg: register offsets, command bit positions, signature 16'hace0, state encoding.
- Sub-module sync_fifo (WIDTH, DEPTH): push/pop, full, empty, count[clog2(DEPTH):0]; push to full is ignored; simultaneous push and pop when full is allowed. Instantiate it twice per stream.

Test Plan:
- Stream 1: ctrl=3, addr=0x1000_0000, size=0x400, TREADY=1 → one command {tag=1, addr=0x10000000, EOF=1, INCR=1, BTT=0x400}; status 0x81 → off4 reads 0x00000081, sts_pending[1]=1; pop → empty bit set.
- All 4 streams enabled with 2 commands each, TREADY=1, status returned immediately → issue order 0,1,2,3,0,1,2,3.
- MAX_OUTSTANDING=4 with 6 commands queued and no status → TVALID low after 4 issues; one status returned → 5th issues.
- Write 17 sizes to stream 2 → cmd count 16, ovf=1; write size 0 → zero_err=1 and count unchanged.
- TREADY held low 10 cycles → TDATA stable; stream_ready[0]=0 → stream 0 skipped, others proceed.
- Assert rst during ISSUE → next cycle TVALID=0, all counts 0, reads of off6/off7 return 0.
